// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared encodings for the MIPS HI/LO multiply/divide unit: operation codes,
// FSM states and small decode helpers.
package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_signed_op(input op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

  function automatic logic is_div_op(input op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring subtract for divide. Purely combinational.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // The partial remainder stays below the divisor, so the trial difference
  // always fits in WIDTH bits whenever it is kept.
  always_comb begin
    sum     = {1'b0, a_in} + (q_in[0] ? {1'b0, m_in} : '0);
    shifted = {a_in, q_in[WIDTH-1]};
    ge      = shifted[WIDTH] | (shifted[WIDTH-1:0] >= m_in);
    diff    = shifted[WIDTH-1:0] - m_in;
    if (is_div) begin
      a_out = ge ? diff : shifted[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], ge};
    end else begin
      a_out = sum[WIDTH:1];
      q_out = {sum[0], q_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit with iterative datapath and sign fix-up.
// Define MIPS_CPU_MULDIV_FAST_MULT_EN for a single-cycle MULT/MULTU path.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dbz_q, dbz_d;
  logic             launch;

  op_e              op_in;
  logic             is_div_q;
  logic [WIDTH-1:0] step_a, step_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign op_in    = op_e'(op);
  assign is_div_q = is_div_op(op_q);

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .a_in   (a_q),
    .q_in   (q_q),
    .m_in   (m_q),
    .a_out  (step_a),
    .q_out  (step_q)
  );

  // Magnitude results are re-signed here: quotient negative on differing
  // signs, remainder follows the dividend.
  assign prod_fix = ((op_q == MULT) && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]))
                    ? -{a_q, q_q} : {a_q, q_q};
  assign quot_fix = ((op_q == DIV) && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1])) ? -q_q : q_q;
  assign rem_fix  = ((op_q == DIV) && rs_q[WIDTH-1]) ? -a_q : a_q;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    if (op_in == MULT)
      fast_prod = {{WIDTH{rs_content[WIDTH-1]}}, rs_content}
                * {{WIDTH{rt_content[WIDTH-1]}}, rt_content};
    else
      fast_prod = {{WIDTH{1'b0}}, rs_content} * {{WIDTH{1'b0}}, rt_content};
  end
`endif

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    launch  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op_in)
            MTHI:      hi_d = rs_content;
            MTLO:      lo_d = rs_content;
            DIV, DIVU: launch = 1'b1;
            MULT, MULTU: begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              launch = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (rt_q == '0) begin
          lo_d  = '1;
          hi_d  = rs_q;
          dbz_d = 1'b1;
        end else begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = CALC;
      op_d    = op_in;
      rs_d    = rs_content;
      rt_d    = rt_content;
      cnt_d   = '0;
      a_d     = '0;
      q_d     = is_signed_op(op_in) ? mag(rs_content) : rs_content;
      m_d     = is_signed_op(op_in) ? mag(rt_content) : rt_content;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MULT;
      cnt_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv (WIDTH=32); expectations
// adapt when MIPS_CPU_MULDIV_FAST_MULT_EN is defined.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  localparam int W = 32;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  localparam int   MUL_LAT  = 1;
  localparam logic MUL_BUSY = 1'b0;
`else
  localparam int   MUL_LAT  = W + 2;
  localparam logic MUL_BUSY = 1'b1;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_content, rt_content;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .rs_content  (rs_content),
    .rt_content  (rt_content),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Issues one operation, scrambles the inputs after acceptance and waits
  // for done. lat counts edges with the accepting edge as edge 1.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_seen, output logic dbz_seen);
    @(negedge clk);
    start = 1'b1; op = o; rs_content = a; rt_content = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; rs_content = ~a; rt_content = '0;
    busy_seen = busy;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    dbz_seen = div_by_zero;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 3'd0; rs_content = '0; rt_content = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    n_checks++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [2:0]   vo [5] = '{MULTU, MULT, MULT, MULT, MULTU};
    logic [W-1:0] va [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFC, 32'h00010000};
    logic [W-1:0] vb [5] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'hFFFFFFFA, 32'h00010000};
    logic [W-1:0] vh [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000000, 32'h00000001};
    logic [W-1:0] vl [5] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'h00000018, 32'h00000000};
    int lat; logic bsy, dbz;
    for (int i = 0; i < 5; i++) begin
      run_op(vo[i], va[i], vb[i], lat, bsy, dbz);
      n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult%0d_latency: got %0d expected %0d", i, lat, MUL_LAT); end
      n_checks++; if (hi !== vh[i]) begin n_fail++; $display("FAIL mult%0d_hi: got %h expected %h", i, hi, vh[i]); end
      n_checks++; if (lo !== vl[i]) begin n_fail++; $display("FAIL mult%0d_lo: got %h expected %h", i, lo, vl[i]); end
      n_checks++; if (bsy !== MUL_BUSY) begin n_fail++; $display("FAIL mult%0d_busy: got %b expected %b", i, bsy, MUL_BUSY); end
      n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL mult%0d_dbz: got %b expected 0", i, dbz); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult%0d_done_pulse: got %b expected 0", i, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]   vo [7] = '{DIV, DIV, DIV, DIVU, DIVU, DIV, DIVU};
    logic [W-1:0] va [7] = '{32'hFFFFFFF9, 32'h80000000, 32'h00000007, 32'hFFFFFFFF,
                             32'h00000007, 32'hFFFFFFFB, 32'h00000005};
    logic [W-1:0] vb [7] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000010,
                             32'h00000000, 32'h00000000, 32'h00000007};
    logic [W-1:0] vh [7] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0000000F,
                             32'h00000007, 32'hFFFFFFFB, 32'h00000005};
    logic [W-1:0] vl [7] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'h0FFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    logic         vz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic bsy, dbz;
    for (int i = 0; i < 7; i++) begin
      run_op(vo[i], va[i], vb[i], lat, bsy, dbz);
      n_checks++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, DIV_LAT); end
      n_checks++; if (hi !== vh[i]) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, vh[i]); end
      n_checks++; if (lo !== vl[i]) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, vl[i]); end
      n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL div%0d_busy: got %b expected 1", i, bsy); end
      n_checks++; if (dbz !== vz[i]) begin n_fail++; $display("FAIL div%0d_dbz: got %b expected %b", i, dbz, vz[i]); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin
        n_fail++; $display("FAIL div%0d_pulse: got done=%b dbz=%b expected 0/0", i, done, div_by_zero);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start = 1'b1; op = DIVU; rs_content = 32'd100; rt_content = 32'd3;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 5) begin
        start = 1'b1; op = MULTU; rs_content = 32'd2; rt_content = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected %0d", lat, DIV_LAT); end
    n_checks++; if (lo !== 32'd33) begin n_fail++; $display("FAIL busy_ignore_lo: got %h expected %h", lo, 32'd33); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL busy_ignore_hi: got %h expected %h", hi, 32'd1); end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_ignore_quiet: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_move();
    @(negedge clk);
    start = 1'b1; op = MTHI; rs_content = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mthi_hi: got %h expected AAAA5555", hi); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0/0", busy, done); end
    start = 1'b1; op = MTLO; rs_content = 32'h0F0F1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (lo !== 32'h0F0F1234) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 0F0F1234", lo); end
    n_checks++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected AAAA5555", hi); end
    for (int o = 6; o < 8; o++) begin
      start = 1'b1; op = 3'(o); rs_content = 32'h13572468; rt_content = 32'h2;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (hi !== 32'hAAAA5555 || lo !== 32'h0F0F1234) begin
        n_fail++; $display("FAIL illegal%0d_hilo: got %h/%h expected AAAA5555/0F0F1234", o, hi, lo);
      end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_flags: got busy=%b done=%b expected 0/0", o, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    @(negedge clk);
    start = 1'b1; op = DIV; rs_content = 32'd1000; rt_content = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== '0 || lo !== '0) begin n_fail++; $display("FAIL midreset_hilo: got %h/%h expected 0/0", hi, lo); end
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1; op = MTLO; rs_content = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (lo !== 32'h00001234) begin n_fail++; $display("FAIL post_reset_mtlo: got %h expected 00001234", lo); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0 || hi !== '0) begin
      n_fail++; $display("FAIL midreset_discard: got done_count=%0d hi=%h expected 0/0", seen_done, hi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_move();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
